// File: rtl/char_row_if.sv
// char_row_if: host byte handshake, blanking input and row-buffer write port.
interface char_row_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       blank;
  logic       write;
  logic [5:0] addr;
  logic [5:0] char_out;
  logic [5:0] cursor;
  logic       busy;
  modport master (output rx_data, rx_valid, blank,
                  input  rx_ready, write, addr, char_out, cursor, busy);
  modport slave  (input  rx_data, rx_valid, blank,
                  output rx_ready, write, addr, char_out, cursor, busy);
endinterface

// File: rtl/char_row_writer.sv
// char_row_writer: command-driven cursor/character writer that only touches the row buffer during blanking.
module char_row_writer #(
  parameter int         COLS       = 64,
  parameter logic [5:0] CLEAR_CHAR = 6'h3F
) (
  input logic       clk,
  input logic       rst,
  char_row_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_BLANK, CLEAR_RUN} state_e;
  localparam logic [5:0] LAST = 6'(COLS - 1);
  state_e     state_q, state_d;
  logic [5:0] cursor_q, cursor_d, addr_q, addr_d, char_q, char_d;
  logic [5:0] pchar_q, pchar_d, clr_q, clr_d;
  logic       write_q, write_d;
  logic [1:0] op;
  logic [5:0] p, cursor_nxt;
  logic       accept, clr_last;
  assign op         = bus.rx_data[7:6];
  assign p          = bus.rx_data[5:0];
  assign accept     = bus.rx_valid & bus.rx_ready;
  assign cursor_nxt = (cursor_q == LAST) ? 6'd0 : cursor_q + 6'd1;
  assign clr_last   = clr_q == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      addr_q   <= '0;
      char_q   <= '0;
      pchar_q  <= '0;
      clr_q    <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      addr_q   <= addr_d;
      char_q   <= char_d;
      pchar_q  <= pchar_d;
      clr_q    <= clr_d;
      write_q  <= write_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (accept) state_d = (op == 2'b00) ? WAIT_BLANK : (op == 2'b10) ? CLEAR_RUN : IDLE;
      WAIT_BLANK: if (bus.blank) state_d = IDLE;
      CLEAR_RUN:  if (bus.blank && clr_last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  // blank low in WAIT_BLANK/CLEAR_RUN simply leaves every register parked
  always_comb begin
    write_d  = 1'b0;
    addr_d   = addr_q;
    char_d   = char_q;
    cursor_d = cursor_q;
    pchar_d  = pchar_q;
    clr_d    = clr_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (op == 2'b00) pchar_d = p;
        if (op == 2'b01 && {1'b0, p} < 7'(COLS)) cursor_d = p;
        if (op == 2'b10) clr_d = '0;
      end
      WAIT_BLANK: if (bus.blank) begin
        write_d  = 1'b1;
        addr_d   = cursor_q;
        char_d   = pchar_q;
        cursor_d = cursor_nxt;
      end
      CLEAR_RUN: if (bus.blank) begin
        write_d  = 1'b1;
        addr_d   = clr_q;
        char_d   = CLEAR_CHAR;
        clr_d    = clr_q + 6'd1;
        cursor_d = clr_last ? 6'd0 : cursor_q;
      end
      default: ;
    endcase
  end
  assign bus.rx_ready = (state_q == IDLE) & ~rst;
  assign bus.busy     = state_q != IDLE;
  assign bus.write    = write_q;
  assign bus.addr     = addr_q;
  assign bus.char_out = char_q;
  assign bus.cursor   = cursor_q;
endmodule
